// File: rtl/count_ctrl.sv
// Start/stop/clear BCD counter for a four-digit display, with debounced buttons,
// selectable count direction and a timed buzzer alarm whenever the count wraps.
module count_ctrl #(
    parameter int DIV         = 50_000_000,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int BUZZ_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        sw_dir,
    output logic [15:0] disp_hexs,
    output logic [3:0]  disp_points,
    output logic [3:0]  disp_les,
    output logic        Rc,
    output logic        buzzer,
    output logic [1:0]  state
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(DIV / 2);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    // One BCD step up or down, with carry/borrow rippling across all four digits.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[i*4 +: 4];
            if (c) begin
                if (!down) begin
                    r[i*4 +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                    c           = (d == 4'd9);
                end else begin
                    r[i*4 +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                    c           = (d == 4'd0);
                end
            end
        end
        return r;
    endfunction

    // Bit order in the synchroniser: {sw_dir, btn_clear, btn_start}.
    logic [2:0] sync_q1, sync_q2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {sw_dir, btn_clear, btn_start};
            sync_q2 <= sync_q1;
        end
    end

    logic [1:0]       deb_lvl;
    logic [1:0]       press;
    logic [DEB_W-1:0] deb_cnt [2];

    // NOTE: the debounce counters are a tiny register array, not a RAM, so they
    // are reset element by element like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
            deb_lvl <= '0;
            press   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_q2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    deb_lvl[i] <= sync_q2[i];
                    press[i]   <= sync_q2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    logic start_p, clear_p, dir_s;
    assign start_p = press[0];
    assign clear_p = press[1];
    assign dir_s   = sync_q2[2];

    state_t             cur_state, nxt_state;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [BUZZ_W-1:0]  buzz_q, buzz_d;
    logic               rc_d;
    logic               counting, tick, wrap;

    assign counting = (cur_state == S_RUN) || (cur_state == S_ALARM);
    assign tick     = counting && (div_q == DIV_LAST);
    assign wrap     = tick && (dir_s ? (cnt_q == 16'h0000) : (cnt_q == 16'h9999));

    // NOTE: every variable gets a default first, so no path through the
    // combinational block can leave one unassigned and infer a latch.
    always_comb begin
        nxt_state = cur_state;
        div_d     = div_q;
        cnt_d     = cnt_q;
        buzz_d    = buzz_q;
        rc_d      = wrap;

        if (counting) div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick)     cnt_d = bcd_step(cnt_q, dir_s);
        if (cur_state == S_ALARM) buzz_d = buzz_q + BUZZ_W'(1);

        case (cur_state)
            S_IDLE: begin
                div_d = '0;
                if (start_p) nxt_state = S_RUN;
            end
            S_RUN: begin
                if (start_p) begin
                    nxt_state = S_PAUSE;
                end else if (wrap) begin
                    nxt_state = S_ALARM;
                    buzz_d    = '0;
                end
            end
            S_PAUSE: begin
                if (start_p) nxt_state = S_RUN;
            end
            S_ALARM: begin
                if (start_p)                  nxt_state = S_PAUSE;
                else if (wrap)                buzz_d    = '0;
                else if (buzz_q == BUZZ_LAST) nxt_state = S_RUN;
            end
            default: nxt_state = S_IDLE;
        endcase

        // Clear overrides any start press or tick arriving in the same cycle.
        if (clear_p) begin
            nxt_state = S_IDLE;
            cnt_d     = '0;
            div_d     = '0;
            buzz_d    = '0;
            rc_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            buzz_q    <= '0;
            Rc        <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            buzz_q    <= buzz_d;
            Rc        <= rc_d;
        end
    end

    // Outputs decode registered state only, so reset silences the buzzer at once.
    assign state     = cur_state;
    assign disp_hexs = cnt_q;
    assign buzzer    = (cur_state != S_ALARM);
    assign disp_les  = {cnt_q[15:12] == 4'd0, cnt_q[15:8] == 8'd0, cnt_q[15:4] == 12'd0, 1'b0};

    always_comb begin
        disp_points = 4'b0000;
        case (cur_state)
            S_PAUSE:       disp_points = 4'b1111;
            S_RUN, S_ALARM: disp_points = {3'b000, div_q < DIV_HALF};
            default:       disp_points = 4'b0000;
        endcase
    end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter DIV, default 50_000_000, clk cycles per count tick (1 s at 50 MHz).
REQ-002 Parameter DEB_CYCLES, default 1_000_000, consecutive stable cycles required to accept a button level.
REQ-003 Parameter BUZZ_CYCLES, default 25_000_000, buzzer-on duration in clk cycles after a wrap.
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 btn_start  in  1  raw start/stop pushbutton, active-high, unsynchronised.
REQ-007 btn_clear  in  1  raw clear pushbutton, active-high, unsynchronised.
REQ-008 sw_dir  in  1  count direction, 0 = up, 1 = down; slide switch, unsynchronised.
REQ-009 disp_hexs  out  16  four BCD digits to the display driver, digit 0 (ones) in [3:0].
REQ-010 disp_points  out  4  decimal-point enables, 1 = lit.
REQ-011 disp_les  out  4  per-digit blank enables, 1 = blanked.
REQ-012 Rc  out  1  one-cycle pulse on counter wrap.
REQ-013 buzzer  out  1  active-low buzzer drive, 1 = silent.
REQ-014 state  out  2  FSM state code: IDLE=0, RUN=1, PAUSE=2, ALARM=3.

Function
REQ-015 All three raw inputs SHALL pass a two-flop synchroniser before any other use.
REQ-016 Each button SHALL be debounced: debounced level changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-017 A press SHALL be a one-cycle pulse on the debounced 0->1 edge; releases produce nothing.
REQ-018 Tick divider SHALL count 0..DIV-1 in RUN and ALARM, emit a one-cycle tick at DIV-1 and return to 0; held at 0 in IDLE, frozen in PAUSE.
REQ-019 On tick the 4-digit BCD count SHALL step +1 (sw_dir=0) or -1 (sw_dir=1), digit carry/borrow resolved in the same cycle; sw_dir sampled at the tick.
REQ-020 Wrap: up 9999->0000, down 0000->9999; a wrapping tick SHALL assert Rc that same cycle (registered output, visible the following cycle) for exactly one cycle.
REQ-021 FSM transitions: IDLE-start->RUN; RUN-start->PAUSE; PAUSE-start->RUN (divider resumes from frozen value); RUN-wrap->ALARM; ALARM-start->PAUSE; ALARM after BUZZ_CYCLES->RUN.
REQ-022 Clear press in any state SHALL force IDLE, count 0000, divider 0, buzzer 1 next cycle; clear wins over simultaneous start or tick.
REQ-023 ALARM SHALL keep counting as RUN; a further wrap in ALARM restarts the BUZZ_CYCLES timer.
REQ-024 buzzer SHALL be 0 exactly while in ALARM, else 1.
REQ-025 disp_points: IDLE 4'b0000; PAUSE 4'b1111; RUN/ALARM bit 0 = 1 while divider < DIV/2, bits 3:1 = 0.
REQ-026 disp_les: leading zero digits 3..1 blanked (bit set) when they and all higher digits are 0; digit 0 never blanked.
REQ-027 disp_hexs SHALL reflect the count register directly, no added latency.

Reset
REQ-028 rst asserted SHALL asynchronously force: state IDLE, count 0000, divider 0, debounce counters 0, debounced levels 0, synchronisers 0, Rc 0, buzzer 1, disp_points 0000, disp_les 4'b1110.
REQ-029 After rst release a button already held SHALL need DEB_CYCLES stable cycles and then produce one press.
REQ-030 rst mid-ALARM SHALL silence buzzer immediately without waiting for a clock.

Verification (DIV=10, DEB_CYCLES=4, BUZZ_CYCLES=5)
REQ-031 Start pressed clean from reset -> state 1, disp_hexs 0x0000 then 0x0001 after 10 cycles, 0x0002 after 20.
REQ-032 btn_start glitches 1-cycle pulses, 3-cycle pulse -> no press; 4+ cycle hold -> exactly one press, RUN<->PAUSE toggle.
REQ-033 Up count preloaded to 9999 via running -> tick gives 0x0000, Rc one cycle, buzzer 0 for 5 cycles, state 3 then 1.
REQ-034 sw_dir=1 from 0000 in RUN -> next tick 0x9999, Rc pulse, ALARM; digits borrow correctly 0x1000->0x0999.
REQ-035 Clear and start pressed same cycle in PAUSE with count 0x0042 -> IDLE, 0x0000, disp_les 4'b1110, points 0000.
REQ-036 rst asserted between clock edges during ALARM -> buzzer 1, state 0, count 0 before next rising edge.
